// File: rtl/memory_access.sv
// memory_access: RV32I memory stage performing loads/stores over a req/ack data bus
module memory_access (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_mem_valid,
  input  logic [31:0] ex_mem_pc,
  input  logic [31:0] ex_mem_ir,
  input  logic [31:0] ex_mem_alu_out,
  input  logic [31:0] ex_mem_rs2,
  output logic        mem_stall,
  output logic        mem_wb_valid,
  output logic [31:0] mem_wb_pc,
  output logic [31:0] mem_wb_ir,
  output logic [31:0] mem_wb_alu_out,
  output logic        mem_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);
  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_STORE = 7'b0100011;
  localparam logic [31:0] NOP      = 32'h00000013;
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t      state;
  logic [31:0] pc_q, ir_q, ea_q, rs2_q;
  logic [2:0]  f3_q;
  logic        st_q;
  logic [2:0]  f3;
  logic        is_ld, is_st, legal, aligned, ok;
  logic [31:0] rsh, ld_data;
  logic [15:0] half;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  always_comb begin
    f3       = ex_mem_ir[14:12];
    is_ld    = ex_mem_ir[6:0] == OP_LOAD;
    is_st    = ex_mem_ir[6:0] == OP_STORE;
    legal    = is_ld ? (f3 != 3'b011 && f3[2:1] != 2'b11) : (f3[2] == 1'b0 && f3[1:0] != 2'b11);
    aligned  = f3[1] ? ex_mem_alu_out[1:0] == 2'b00 : f3[0] ? ~ex_mem_alu_out[0] : 1'b1;
    ok       = legal & aligned;
    mem_stall = (state == IDLE && ex_mem_valid && (is_ld | is_st) && ok) || (state == ACCESS && !dmem_ack);
    rsh      = dmem_rdata >> {ea_q[1:0], 3'b000};
    half     = ea_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    ld_data  = f3_q[1] ? dmem_rdata : f3_q[0] ? {{16{~f3_q[2] & half[15]}}, half} : {{24{~f3_q[2] & rsh[7]}}, rsh[7:0]};
    be_c     = f3_q[1] ? 4'b1111 : f3_q[0] ? 4'b0011 << {ea_q[1], 1'b0} : 4'b0001 << ea_q[1:0];
    wdata_c  = f3_q[1] ? rs2_q : f3_q[0] ? {2{rs2_q[15:0]}} : {4{rs2_q[7:0]}};
    dmem_req   = state == ACCESS;
    dmem_we    = dmem_req & st_q;
    dmem_addr  = dmem_req ? {ea_q[31:2], 2'b00} : 32'h0;
    dmem_be    = dmem_req ? be_c : 4'h0;
    dmem_wdata = dmem_req ? wdata_c : 32'h0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      pc_q           <= '0;
      ir_q           <= '0;
      ea_q           <= '0;
      rs2_q          <= '0;
      f3_q           <= '0;
      st_q           <= 1'b0;
      mem_wb_valid   <= 1'b0;
      mem_wb_pc      <= '0;
      mem_wb_ir      <= '0;
      mem_wb_alu_out <= '0;
      mem_err        <= 1'b0;
    end else begin
      mem_wb_valid <= 1'b0;
      mem_err      <= 1'b0;
      if (state == IDLE && ex_mem_valid) begin
        if (!(is_ld | is_st)) begin
          mem_wb_valid   <= 1'b1;
          mem_wb_pc      <= ex_mem_pc;
          mem_wb_ir      <= ex_mem_ir;
          mem_wb_alu_out <= ex_mem_alu_out;
        end else if (ok) begin
          state <= ACCESS;
          pc_q  <= ex_mem_pc;
          ir_q  <= ex_mem_ir;
          ea_q  <= ex_mem_alu_out;
          rs2_q <= ex_mem_rs2;
          f3_q  <= f3;
          st_q  <= is_st;
        end else begin
          mem_wb_valid   <= 1'b1;
          mem_wb_pc      <= ex_mem_pc;
          mem_wb_ir      <= NOP;
          mem_wb_alu_out <= '0;
          mem_err        <= 1'b1;
        end
      end else if (state == ACCESS && dmem_ack) begin
        state          <= IDLE;
        mem_wb_valid   <= 1'b1;
        mem_wb_pc      <= pc_q;
        mem_wb_ir      <= ir_q;
        mem_wb_alu_out <= st_q ? ea_q : ld_data;
      end
    end
  end
endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: directed vector table plus reset and back-to-back sequences
module tb_memory_access;
  logic        clk = 0, rst_n = 0, ex_mem_valid = 0;
  logic [31:0] ex_mem_pc = 0, ex_mem_ir = 0, ex_mem_alu_out = 0, ex_mem_rs2 = 0;
  logic        mem_stall, mem_wb_valid, mem_err, dmem_req, dmem_we;
  logic [31:0] mem_wb_pc, mem_wb_ir, mem_wb_alu_out, dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata = 0;
  logic        dmem_ack = 0;
  int checks = 0, failures = 0;

  memory_access dut (
    .clk(clk), .rst_n(rst_n), .ex_mem_valid(ex_mem_valid), .ex_mem_pc(ex_mem_pc),
    .ex_mem_ir(ex_mem_ir), .ex_mem_alu_out(ex_mem_alu_out), .ex_mem_rs2(ex_mem_rs2),
    .mem_stall(mem_stall), .mem_wb_valid(mem_wb_valid), .mem_wb_pc(mem_wb_pc),
    .mem_wb_ir(mem_wb_ir), .mem_wb_alu_out(mem_wb_alu_out), .mem_err(mem_err),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] ir, ea, rs2, rdata;
    int          wait_n;
    logic        req, we, err;
    logic [31:0] addr, wdata, wb_ir, wb_alu;
    logic [3:0]  be;
    int          stalls;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input logic [31:0] pc);
    int n = 0, st = 0;
    bit seen = 0, got = 0, hold;
    @(negedge clk);
    ex_mem_valid = 1; ex_mem_pc = pc; ex_mem_ir = v.ir; ex_mem_alu_out = v.ea; ex_mem_rs2 = v.rs2;
    dmem_rdata = v.rdata;
    for (int c = 0; c < 40 && !got; c++) begin
      dmem_ack = dmem_req && (n == v.wait_n);
      if (dmem_req) n++;
      #1;
      if (dmem_req && !seen) begin
        seen = 1;
        check({v.name, " addr"}, dmem_addr, v.addr);
        check({v.name, " be"}, {28'h0, dmem_be}, {28'h0, v.be});
        check({v.name, " we"}, {31'h0, dmem_we}, {31'h0, v.we});
        check({v.name, " wdata"}, dmem_wdata, v.wdata);
      end
      if (mem_stall) st++;
      hold = mem_stall;
      @(posedge clk); #1;
      if (!hold) ex_mem_valid = 0;
      dmem_ack = 0;
      if (mem_wb_valid) got = 1;
      else @(negedge clk);
    end
    check({v.name, " wb_valid"}, {31'h0, got}, 32'h1);
    check({v.name, " req_seen"}, {31'h0, seen}, {31'h0, v.req});
    check({v.name, " stalls"}, st, v.stalls);
    check({v.name, " err"}, {31'h0, mem_err}, {31'h0, v.err});
    check({v.name, " wb_pc"}, mem_wb_pc, pc);
    check({v.name, " wb_ir"}, mem_wb_ir, v.wb_ir);
    check({v.name, " wb_alu"}, mem_wb_alu_out, v.wb_alu);
    @(posedge clk); #1;
    check({v.name, " pulse"}, {31'h0, mem_wb_valid}, 32'h0);
    check({v.name, " hold"}, mem_wb_alu_out, v.wb_alu);
  endtask

  vec_t vt[$];

  initial begin
    //        name    ir            ea            rs2           rdata        w  req we err addr          wdata         wb_ir         wb_alu        be      stalls
    vt.push_back('{"add",  32'h002081B3, 32'h00000055, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        32'h0,        32'h002081B3, 32'h00000055, 4'b0000, 0});
    vt.push_back('{"sb",   32'h00208023, 32'h00000103, 32'hAABBCCDD, 32'h0,        3, 1, 1, 0, 32'h00000100, 32'hDDDDDDDD, 32'h00208023, 32'h00000103, 4'b1000, 4});
    vt.push_back('{"lb",   32'h00008183, 32'h00000202, 32'h0,        32'h0080FF00, 0, 1, 0, 0, 32'h00000200, 32'h0,        32'h00008183, 32'hFFFFFF80, 4'b0100, 1});
    vt.push_back('{"lbu",  32'h0000C183, 32'h00000202, 32'h0,        32'h0080FF00, 0, 1, 0, 0, 32'h00000200, 32'h0,        32'h0000C183, 32'h00000080, 4'b0100, 1});
    vt.push_back('{"lh_mis",32'h00009183,32'h00000201, 32'h0,        32'h0,        0, 0, 0, 1, 32'h0,        32'h0,        32'h00000013, 32'h0,        4'b0000, 0});
    vt.push_back('{"sh",   32'h00209023, 32'h00000402, 32'h1234ABCD, 32'h0,        1, 1, 1, 0, 32'h00000400, 32'hABCDABCD, 32'h00209023, 32'h00000402, 4'b1100, 2});
    vt.push_back('{"sw",   32'h0020A023, 32'h00000500, 32'hCAFEBABE, 32'h0,        2, 1, 1, 0, 32'h00000500, 32'hCAFEBABE, 32'h0020A023, 32'h00000500, 4'b1111, 3});
    vt.push_back('{"lhu",  32'h0000D183, 32'h00000302, 32'h0,        32'h80011234, 0, 1, 0, 0, 32'h00000300, 32'h0,        32'h0000D183, 32'h00008001, 4'b1100, 1});
    vt.push_back('{"lh",   32'h00009183, 32'h00000302, 32'h0,        32'h80011234, 1, 1, 0, 0, 32'h00000300, 32'h0,        32'h00009183, 32'hFFFF8001, 4'b1100, 2});
    vt.push_back('{"lw_mis",32'h0000A183,32'h00000302, 32'h0,        32'h0,        0, 0, 0, 1, 32'h0,        32'h0,        32'h00000013, 32'h0,        4'b0000, 0});
    vt.push_back('{"ld_f3",32'h0000B183, 32'h00000000, 32'h0,        32'h0,        0, 0, 0, 1, 32'h0,        32'h0,        32'h00000013, 32'h0,        4'b0000, 0});
    vt.push_back('{"st_f3",32'h0020C023, 32'h00000000, 32'h0,        32'h0,        0, 0, 0, 1, 32'h0,        32'h0,        32'h00000013, 32'h0,        4'b0000, 0});
    vt.push_back('{"lw",   32'h0000A183, 32'h00000300, 32'h0,        32'h12345678, 0, 1, 0, 0, 32'h00000300, 32'h0,        32'h0000A183, 32'h12345678, 4'b1111, 1});

    #12;
    check("rst req", {31'h0, dmem_req}, 32'h0);
    check("rst valid", {31'h0, mem_wb_valid}, 32'h0);
    check("rst err", {31'h0, mem_err}, 32'h0);
    check("rst wb_pc", mem_wb_pc, 32'h0);
    check("rst wb_alu", mem_wb_alu_out, 32'h0);
    check("rst be", {28'h0, dmem_be}, 32'h0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    check("idle no valid", {31'h0, mem_wb_valid}, 32'h0);

    for (int i = 0; i < vt.size(); i++) run(vt[i], 32'h1000 + 32'(i * 4));

    // reset while a load waits for its ack
    @(negedge clk);
    ex_mem_valid = 1; ex_mem_pc = 32'h2000; ex_mem_ir = 32'h0000A183; ex_mem_alu_out = 32'h300;
    @(posedge clk); #1;
    check("rstacc req", {31'h0, dmem_req}, 32'h1);
    @(negedge clk) rst_n = 0;
    #1;
    check("rstacc req drop", {31'h0, dmem_req}, 32'h0);
    ex_mem_valid = 0;
    @(negedge clk) rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("rstacc no valid", {31'h0, mem_wb_valid}, 32'h0);
      check("rstacc idle", {31'h0, dmem_req}, 32'h0);
    end

    // LW then ADDI back to back
    @(negedge clk);
    ex_mem_valid = 1; ex_mem_pc = 32'h3000; ex_mem_ir = 32'h0000A183; ex_mem_alu_out = 32'h300;
    dmem_rdata = 32'h12345678;
    @(posedge clk); #1;
    @(negedge clk) dmem_ack = 1;
    #1;
    check("b2b stall ack", {31'h0, mem_stall}, 32'h0);
    @(posedge clk); #1;
    dmem_ack = 0;
    check("b2b lw valid", {31'h0, mem_wb_valid}, 32'h1);
    check("b2b lw data", mem_wb_alu_out, 32'h12345678);
    ex_mem_pc = 32'h3004; ex_mem_ir = 32'h00508093; ex_mem_alu_out = 32'h77;
    @(posedge clk); #1;
    ex_mem_valid = 0;
    check("b2b addi valid", {31'h0, mem_wb_valid}, 32'h1);
    check("b2b addi data", mem_wb_alu_out, 32'h77);
    check("b2b addi pc", mem_wb_pc, 32'h3004);
    @(posedge clk); #1;
    check("b2b end", {31'h0, mem_wb_valid}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
